// File: rtl/addsub_arbiter.sv
// addsub_arbiter
//   Two requesters share one 16-bit adder/subtractor through a round-robin
//   arbiter and a three-state FSM (IDLE -> EXEC -> RESP -> IDLE).
//   Accept at edge T, result presented from T+2, one op per 3 cycles peak.
//
// Ports
//   clk, reset                 : clock, synchronous active-high reset
//   reqk_valid / reqk_ready    : request handshake for requester k (k = 0,1)
//   reqk_a, reqk_b             : 16-bit operands
//   reqk_sub                   : 0 = A+B, 1 = A-B
//   reqk_signed                : 1 = report two's-complement overflow
//   resp_valid / resp_ready    : response handshake
//   resp_id                    : requester that owns the result
//   resp_sum, resp_carry       : result mod 2^16 and carry-out
//   resp_ovf                   : signed overflow (0 when signed = 0)
//   busy                       : FSM not in IDLE
//   grant_cnt0, grant_cnt1     : saturating per-requester grant counters
//
// Optional feature: define ADDSUB_ARBITER_STATS_EN to build the grant
// counters; otherwise grant_cnt0/grant_cnt1 are constant 0.

module addsub_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   input  logic        req1_valid,
   output logic        req0_ready,
   output logic        req1_ready,
   input  logic [15:0] req0_a,
   input  logic [15:0] req0_b,
   input  logic [15:0] req1_a,
   input  logic [15:0] req1_b,
   input  logic        req0_sub,
   input  logic        req1_sub,
   input  logic        req0_signed,
   input  logic        req1_signed,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic        resp_id,
   output logic [15:0] resp_sum,
   output logic        resp_carry,
   output logic        resp_ovf,
   output logic        busy,
   output logic [15:0] grant_cnt0,
   output logic [15:0] grant_cnt1
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t      state, state_nxt;
   logic        gnt0, gnt1;
   logic        last_grant;   // id granted most recently; reset value 1 favours req0
   logic [15:0] op_a, op_b;
   logic        op_sub, op_signed, op_id;

   // Datapath: A + (B ^ {16{sub}}) + sub
   logic [15:0] b_eff;
   logic [16:0] add_full;
   logic        ovf_calc;

   assign b_eff    = op_b ^ {16{op_sub}};
   assign add_full = {1'b0, op_a} + {1'b0, b_eff} + {16'd0, op_sub};
   // Overflow: operand signs agree but result sign differs
   assign ovf_calc = op_signed & ~(op_a[15] ^ b_eff[15]) & (add_full[15] ^ op_a[15]);

   always_comb begin
      state_nxt = state;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      case (state)
         IDLE: begin
            // Ready is gated by reset so nothing is accepted in a reset cycle
            if (!reset) begin
               gnt0 = req0_valid & (~req1_valid | last_grant);
               gnt1 = req1_valid & (~req0_valid | ~last_grant);
               if (gnt0 | gnt1) state_nxt = EXEC;
            end
         end
         EXEC:    state_nxt = RESP;
         RESP:    if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign resp_valid = (state == RESP);
   assign busy       = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         op_a       <= '0;
         op_b       <= '0;
         op_sub     <= 1'b0;
         op_signed  <= 1'b0;
         op_id      <= 1'b0;
         resp_id    <= 1'b0;
         resp_sum   <= '0;
         resp_carry <= 1'b0;
         resp_ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (gnt0 | gnt1) begin
            op_a       <= gnt1 ? req1_a      : req0_a;
            op_b       <= gnt1 ? req1_b      : req0_b;
            op_sub     <= gnt1 ? req1_sub    : req0_sub;
            op_signed  <= gnt1 ? req1_signed : req0_signed;
            op_id      <= gnt1;
            last_grant <= gnt1;
         end
         // Result registers only load in EXEC, so they hold through RESP stalls
         if (state == EXEC) begin
            resp_sum   <= add_full[15:0];
            resp_carry <= add_full[16];
            resp_ovf   <= ovf_calc;
            resp_id    <= op_id;
         end
      end
   end

`ifdef ADDSUB_ARBITER_STATS_EN
   logic [15:0] cnt0, cnt1;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else begin
         if (gnt0 && cnt0 != 16'hFFFF) cnt0 <= cnt0 + 16'd1;
         if (gnt1 && cnt1 != 16'hFFFF) cnt1 <= cnt1 + 16'd1;
      end
   end

   assign grant_cnt0 = cnt0;
   assign grant_cnt1 = cnt1;
`else
   assign grant_cnt0 = '0;
   assign grant_cnt1 = '0;
`endif

endmodule
